data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 88 ++++++++
 tb/tb_data_mem_responder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed scratch memory behind a req/ready handshake with a fixed
// WAIT-cycle latency; misaligned or out-of-range accesses answer with err.
module data_mem_responder #(
  parameter int WAIT   = 2,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] WLAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  logic [31:0] mem [2**ADDR_W];

  logic        accept, enter_resp;
  logic        s_we, s_bad, c_bad;
  logic [31:0] s_addr, s_wdata;

  assign accept = (state == IDLE) && req;
  assign enter_resp = (accept && (WAIT == 0)) || ((state == BUSY) && (cnt == WLAST));

  // With WAIT=0 the commit edge is also the accept edge, so write from the
  // live inputs there and from the captured copy otherwise.
  assign s_we    = (state == IDLE) ? we    : c_we;
  assign s_addr  = (state == IDLE) ? addr  : c_addr;
  assign s_wdata = (state == IDLE) ? wdata : c_wdata;
  assign s_bad   = (s_addr[1:0] != 2'b00) || (s_addr[31:ADDR_W+2] != '0);
  assign c_bad   = (c_addr[1:0] != 2'b00) || (c_addr[31:ADDR_W+2] != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      c_we    <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          c_we    <= we;
          c_addr  <= addr;
          c_wdata <= wdata;
          cnt     <= '0;
          state   <= (WAIT == 0) ? RESP : BUSY;
        end
        BUSY: begin
          if (cnt == WLAST) state <= RESP;
          else              cnt   <= cnt + 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset at the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && s_we && !s_bad)
      mem[s_addr[ADDR_W+1:2]] <= s_wdata;
  end

  always_comb begin
    ready = (state == RESP);
    busy  = (state != IDLE);
    err   = ready && c_bad;
    rdata = '0;
    if (ready && !c_bad && !c_we)
      rdata = mem[c_addr[ADDR_W+1:2]];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: WAIT=2 instance for functional scenarios, WAIT=0 instance
// for back-to-back streaming.
module tb_data_mem_responder;
  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;

  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0, busy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT(WAIT), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  data_mem_responder #(.WAIT(0), .ADDR_W(10)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction on the WAIT=2 instance; scr scrambles the inputs while busy.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd,
                     input logic exp_err, input bit scr);
    int k;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    if (scr) begin we = ~w; addr = a ^ 32'h4; wdata = ~d; end
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    k = 0;
    while (!ready && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, k, WAIT);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rdata, exp_rd);
    @(posedge clk); #1;
    chk({tag, "_rdy_drop"}, {31'd0, ready}, 32'd0);
    chk({tag, "_idle"}, {29'd0, busy, err, |rdata}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req = 0; we = 0; addr = 0; wdata = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    repeat (2) @(negedge clk);
    chk("rst_out", {29'd0, ready, err, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cnt", {28'd0, dut.cnt}, 32'd0);
    chk("rst_caddr", dut.c_addr, 32'd0);
    reset = 1'b0;

    txn("wr10",   1'b1, 32'h10,   32'hDEADBEEF, 32'd0,        1'b0, 0);
    txn("rd10",   1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 0);
    txn("rd13",   1'b0, 32'h13,   32'h0,        32'd0,        1'b1, 0);
    txn("rd10b",  1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 0);
    txn("wr0",    1'b1, 32'h0,    32'hCAFEF00D, 32'd0,        1'b0, 0);
    txn("wr1000", 1'b1, 32'h1000, 32'h12345678, 32'd0,        1'b1, 0);
    txn("rd0",    1'b0, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0, 0);
    txn("wrhi",   1'b1, 32'h8000_0000, 32'h1111, 32'd0,       1'b1, 0);
    txn("rdtop",  1'b1, 32'hFFC,  32'h0F0F0F0F, 32'd0,        1'b0, 0);
    txn("rdtopb", 1'b0, 32'hFFC,  32'h0,        32'h0F0F0F0F, 1'b0, 0);

    // reset one cycle after acceptance abandons the write
    txn("wr4",    1'b1, 32'h4,    32'hA5A5A5A5, 32'd0,        1'b0, 0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'h1;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mrst_out", {29'd0, ready, err, busy}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mrst_rdy", {31'd0, ready}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("mrst_norsp", {31'd0, ready}, 32'd0);
    end
    txn("rd4",    1'b0, 32'h4,    32'h0,        32'hA5A5A5A5, 1'b0, 0);

    // inputs changed while busy must not affect the captured transaction
    txn("wr24",   1'b1, 32'h24,   32'h77777777, 32'd0,        1'b0, 0);
    txn("wr20s",  1'b1, 32'h20,   32'h55555555, 32'd0,        1'b0, 1);
    txn("rd20",   1'b0, 32'h20,   32'h0,        32'h55555555, 1'b0, 0);
    txn("rd24",   1'b0, 32'h24,   32'h0,        32'h77777777, 1'b0, 0);
    txn("rd10s",  1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 1);
    txn("rd10c",  1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 0);

    // WAIT=0 with req held: IDLE/RESP alternate every cycle
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h600DF00D;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("b2b_rdy",  {31'd0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b2b_busy", {31'd0, busy0},  (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    we0 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_rd_rdy", {31'd0, ready0}, 32'd1);
    chk("b2b_rd", rdata0, 32'h600DF00D);
    chk("b2b_rd_err", {31'd0, err0}, 32'd0);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", {30'd0, ready0, busy0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
